// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider answering execute's
// divide handshake. Execute holds start_i with operands until ready_o, then
// takes result_o = {remainder, quotient} for HI/LO.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous, active-high reset
//   signed_div_i  1 = signed (DIV), 0 = unsigned (DIVU); sampled at acceptance
//   opdata1_i     dividend, sampled at acceptance
//   opdata2_i     divisor, sampled at acceptance
//   start_i       divide request, held until ready_o is seen
//   annul_i       abort request (only when DIV_ANNUL_EN is defined)
//   result_o      {remainder, quotient}; zero unless ready_o
//   ready_o       result valid
//
// Optional feature macro: DIV_ANNUL_EN adds annul_i, which aborts any
// operation in progress (or a finished one) and blocks acceptance in FREE.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
`ifdef DIV_ANNUL_EN
  input  logic                annul_i,
`endif
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_t;

  state_t state, state_nx;

  logic                annul;
  logic                accept;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   quot;
  logic [DATA_W-1:0]   dvs;
  logic                sign1;
  logic                sign2;
  logic                sgn_op;
  logic [2*DATA_W-1:0] result;
  logic [DATA_W:0]     upper;
  logic                ge;

  // Two's-complement negate when requested; used both for taking operand
  // magnitudes and for restoring result signs.
  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] x,
                                               input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

`ifdef DIV_ANNUL_EN
  assign annul = annul_i;
`else
  assign annul = 1'b0;
`endif

  assign accept = (state == FREE) && start_i && !annul;

  // Partial remainder after the shift: remainder gains the next dividend bit
  // from the top of the quotient register. One extra bit keeps the compare
  // against the divisor exact.
  assign upper = {rem, quot[DATA_W-1]};
  assign ge    = (upper >= {1'b0, dvs});

  always_ff @(posedge clk) begin
    if (rst) state <= FREE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FREE:    if (accept) state_nx = (opdata2_i == '0) ? BY_ZERO : ON;
      BY_ZERO: state_nx = END;
      ON:      if (cnt == CNT_LAST) state_nx = END;
      END:     if (!start_i) state_nx = FREE;
      default: state_nx = FREE;
    endcase
    if (annul && state != FREE) state_nx = FREE;
  end

  // Datapath: operand capture at acceptance, one restoring step per cycle in
  // ON, sign fix on the final ON cycle. Remainder follows the dividend's sign.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      rem    <= '0;
      quot   <= '0;
      dvs    <= '0;
      sign1  <= 1'b0;
      sign2  <= 1'b0;
      sgn_op <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        FREE: begin
          if (accept && opdata2_i != '0) begin
            sgn_op <= signed_div_i;
            sign1  <= opdata1_i[DATA_W-1];
            sign2  <= opdata2_i[DATA_W-1];
            quot   <= neg_if(opdata1_i, signed_div_i && opdata1_i[DATA_W-1]);
            dvs    <= neg_if(opdata2_i, signed_div_i && opdata2_i[DATA_W-1]);
            rem    <= '0;
            cnt    <= '0;
          end
          result <= '0;
        end
        ON: begin
          if (cnt != CNT_LAST) begin
            rem  <= ge ? DATA_W'(upper - {1'b0, dvs}) : upper[DATA_W-1:0];
            quot <= {quot[DATA_W-2:0], ge};
            cnt  <= cnt + 1'b1;
          end else begin
            result <= {neg_if(rem, sgn_op && sign1),
                       neg_if(quot, sgn_op && (sign1 ^ sign2))};
          end
        end
        BY_ZERO: result <= '0;
        END:     if (state_nx == FREE) result <= '0;
        default: result <= '0;
      endcase
    end
  end

  assign ready_o  = (state == END);
  assign result_o = ready_o ? result : '0;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
`ifdef DIV_ANNUL_EN
    .annul_i      (annul),
`endif
    .result_o     (result),
    .ready_o      (ready)
  );

  // Reference: plain 64-bit arithmetic (truncating division, remainder keeps
  // dividend sign), zero result for a zero divisor.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present an operation, count edges until ready, verify latency and result,
  // then release start and verify the return to idle.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic scramble, input logic [63:0] exp);
    int n;
    int lat;
    @(negedge clk);
    opdata1 = a; opdata2 = b; signed_div = s; start = 1'b1;
    n = 0;
    while (n < 60 && !ready) begin
      @(posedge clk); #1;
      n++;
      if (scramble) begin
        opdata1 = $urandom; opdata2 = $urandom; signed_div = 1'($urandom);
      end
    end
    lat = (b == 32'd0) ? 2 : 34;
    check({tag, "_latency"}, 64'(n), 64'(lat));
    check({tag, "_result"}, result, exp);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    check({tag, "_idle_ready"}, 64'(ready), 64'd0);
    check({tag, "_idle_result"}, result, 64'd0);
  endtask

  initial begin
    int n;
    int hi_cnt;
    logic [31:0] a, b;
    logic s;
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    opdata1 = '0; opdata2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_result", result, 64'd0);
    @(negedge clk); rst = 1'b0;

    run_div("u_100_7", 32'd100, 32'd7, 1'b0, 1'b0, {32'd2, 32'd14});
    check("u_100_7_model", model(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
    run_div("s_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_div("u_m7_2", 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, {32'h00000001, 32'h7FFFFFFC});
    run_div("s_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, {32'h0, 32'h80000000});
    run_div("u_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, {32'h80000000, 32'h0});
    run_div("scramble", 32'd100, 32'd7, 1'b0, 1'b1, {32'd2, 32'd14});

    // Divide by zero with start held for five extra cycles.
    @(negedge clk);
    opdata1 = 32'h1234; opdata2 = 32'd0; signed_div = 1'b0; start = 1'b1;
    n = 0;
    while (n < 60 && !ready) begin @(posedge clk); #1; n++; end
    check("dz_latency", 64'(n), 64'd2);
    check("dz_result", result, 64'd0);
    hi_cnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ready && result == 64'd0) hi_cnt++;
    end
    check("dz_hold", 64'(hi_cnt), 64'd5);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    check("dz_idle", {result[62:0], ready}, 64'd0);

    // Reset in the middle of ON with start still held.
    @(negedge clk);
    opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", 64'(ready), 64'd0);
    check("midrst_result", result, 64'd0);
    @(negedge clk); rst = 1'b0;
    n = 0;
    while (n < 60 && !ready) begin @(posedge clk); #1; n++; end
    check("midrst_latency", 64'(n), 64'd34);
    check("midrst_result2", result, {32'd2, 32'd14});
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;

`ifdef DIV_ANNUL_EN
    @(negedge clk);
    opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
    hi_cnt = 0;
    repeat (11) begin @(posedge clk); #1; if (ready) hi_cnt++; end
    @(negedge clk); annul = 1'b1; start = 1'b0;
    @(negedge clk); annul = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (ready) hi_cnt++; end
    check("annul_no_ready", 64'(hi_cnt), 64'd0);
    check("annul_result", result, 64'd0);
`endif

    // Randomised operands against the reference model.
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom);
      case (i % 6)
        0: b = 32'($urandom_range(1, 15));
        1: b = 32'd0;
        2: a = 32'($urandom_range(0, 1000));
        3: b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      run_div($sformatf("rand%0d", i), a, b, s, 1'b0, model(a, b, s));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
